dataram_seq: RTL
================

# dataram_seq

Access sequencer and two-port arbiter in front of the internal data RAM (0x00–0x7F: register banks, bit-addressable area, byte area). It accepts byte, bit and register-indirect (@Ri) requests from the core execute port (p0) and the stack/interrupt port (p1). It resolves 8051 bit addresses and the active register bank, and issues exactly one RAM access cycle per operation. All RAM control outputs are registered, so the RAM never sees a glitching chip select or write strobe.

## Interface
- RR, 1, 1 = round-robin between p0/p1; 0 = fixed priority p0
- ADDR_LIMIT, 8'h80, first byte address outside the RAM; indirect pointers >= this value are errors
- clk  input  1  clock, all state on rising edge
- reset  input  1  asynchronous, active-low; clears all state
- psw_rs  input  2  active register bank (PSW.RS1:RS0), sampled at grant
- pN_req  input  1  request valid, held until pN_ack (N = 0, 1)
- pN_ack  output  1  one-cycle grant pulse; request fields latched this cycle
- pN_we  input  1  1 = write, 0 = read
- pN_bit  input  1  1 = bit access (pN_addr is an 8051 bit address), 0 = byte access
- pN_ind  input  1  byte access via @Ri; pN_addr[0] selects R0/R1
- pN_addr  input  8  byte address, bit address, or Ri select
- pN_wdata  input  8  byte write data
- pN_wbit  input  1  bit write data
- rsp_valid  output  1  one-cycle completion pulse
- rsp_port  output  1  port the response belongs to
- rsp_err  output  1  request rejected, no RAM write performed
- rsp_data  output  8  read byte (0 for writes/errors)
- rsp_bit  output  1  read bit (0 for writes/errors)
- ram_CS  output  1  RAM chip select, low active
- ram_RW  output  1  1 read, 0 write
- ram_Bb  output  1  1 byte, 0 bit
- ram_addr  output  8  RAM byte address
- ram_pos  output  8  one-hot bit position
- ram_din  output  8  RAM write byte
- ram_bin  output  1  RAM write bit
- ram_dout  input  8  RAM read byte, valid within the CS cycle
- ram_bout  input  1  RAM read bit, valid within the CS cycle

## Operation
- FSM states: IDLE, PTR, ACC, RSP.
- IDLE:
  - With no request, the block stays in IDLE.
  - Otherwise it grants one port (pN_ack=1), latches that port's fields and psw_rs, and goes to PTR if the request is indirect, else to ACC.
  - An invalid request goes straight to RSP with err. Invalid means: bit access with addr[7]=1 (SFR bit space), or direct byte addr >= ADDR_LIMIT.
- Arbitration:
  - RR=1: on a simultaneous request, the port not granted last wins. After reset, p0 is preferred.
  - RR=0: p0 always wins.
  - Grants occur only in IDLE, so there is at most one operation in flight.
- Address forming:
  - Bit access: ram_addr = {4'h2, addr[6:3]}, ram_pos = 1<<addr[2:0], ram_Bb=0.
  - Byte access: ram_Bb=1, ram_pos=8'hFF.
  - Indirect pointer address: {3'b000, rs, 2'b00, addr[0]}.
- PTR:
  - One byte read cycle at the pointer address. ram_dout is captured as the target address.
  - If the target >= ADDR_LIMIT, go to RSP with err. Otherwise go to ACC.
  - pN_bit is ignored when pN_ind=1.
- ACC:
  - One RAM cycle with CS=0, RW = ~we.
  - Reads capture ram_dout (byte) or ram_bout (bit) into rsp registers.
- RSP:
  - rsp_valid=1 for one cycle, with rsp_port/rsp_err/rsp_data/rsp_bit stable in that cycle. Then return to IDLE.
- Outside PTR/ACC: ram_CS=1, ram_RW=1. ram_RW=0 only when ram_CS=0 in ACC.
- Reset:
  - All outputs return to their reset values: ram_CS=1, ram_RW=1, ram_Bb=1, ram_addr/ram_pos/ram_din=0, ram_bin=0, pN_ack=0, rsp_*=0. State returns to IDLE and the RR pointer prefers p0.
  - Reset asserted mid-operation aborts it. CS deasserts asynchronously and no response is issued.

## Timing
- Direct access: ack in cycle T, CS low in T+1, rsp_valid in T+2.
- Indirect access: ack T, pointer read T+1, target access T+2, rsp_valid T+3.
- Error: rsp_valid at T+1 (direct or bit address) or T+2 (bad pointer), with no ACC cycle.
- Next grant: IDLE is re-entered after RSP, so the earliest next ack is in the cycle after rsp_valid. Peak throughput is one direct op per 3 cycles.
- All ram_* outputs are registers and change only on clk edges; addr/pos/din are stable for the whole CS-low cycle.

## Configuration
- DATARAM_SEQ_INDIRECT_EN defined: @Ri indirect support as above (PTR state, psw_rs used).
- Not defined:
  - PTR logic and psw_rs are unused.
  - Any request with pN_ind=1 is acked and answered at T+1 with rsp_err=1, with no RAM cycle.

## Test plan
- p0 byte write 0x45←0xA5, then read 0x45 → ACC cycle shows CS=0, RW=0, Bb=1, din=0xA5; read response rsp_data=0xA5, rsp_err=0, two cycles after ack.
- p1 bit write bit 0x0B←1, then bit read 0x0B → ram_addr=0x21, ram_pos=0x08, Bb=0; rsp_bit=1. Bit read 0x8B → rsp_err=1 at T+1, CS never low.
- psw_rs=2, R1 (addr 0x11) holds 0x30, indirect write via @R1 of 0x5A → PTR reads 0x11, ACC writes 0x30; R1=0x90 → rsp_err=1 at T+2, no write.
- p0 and p1 requesting continuously, RR=1 → acks alternate p0,p1,p0…; with RR=0 → p0 only.
- reset asserted during ACC of a write → ram_CS=1 immediately, no rsp_valid, next grant goes to p0.

Source files
------------

// File: rtl/dataram_seq.sv
// dataram_seq: access sequencer and two-port arbiter for the 8051 internal data RAM.
// Define DATARAM_SEQ_INDIRECT_EN to enable @Ri indirect accesses (PTR state, psw_rs).
module dataram_seq #(
  parameter bit         RR         = 1'b1,
  parameter logic [7:0] ADDR_LIMIT = 8'h80
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] psw_rs,
  input  logic       p0_req,
  output logic       p0_ack,
  input  logic       p0_we,
  input  logic       p0_bit,
  input  logic       p0_ind,
  input  logic [7:0] p0_addr,
  input  logic [7:0] p0_wdata,
  input  logic       p0_wbit,
  input  logic       p1_req,
  output logic       p1_ack,
  input  logic       p1_we,
  input  logic       p1_bit,
  input  logic       p1_ind,
  input  logic [7:0] p1_addr,
  input  logic [7:0] p1_wdata,
  input  logic       p1_wbit,
  output logic       rsp_valid,
  output logic       rsp_port,
  output logic       rsp_err,
  output logic [7:0] rsp_data,
  output logic       rsp_bit,
  output logic       ram_CS,
  output logic       ram_RW,
  output logic       ram_Bb,
  output logic [7:0] ram_addr,
  output logic [7:0] ram_pos,
  output logic [7:0] ram_din,
  output logic       ram_bin,
  input  logic [7:0] ram_dout,
  input  logic       ram_bout
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PTR  = 2'd1,
    ACC  = 2'd2,
    RSP  = 2'd3
  } state_t;

  state_t state, state_n;

  logic       last, last_n;
  logic       go, gnt1;
  logic       s_we, s_bit, s_ind, s_wbit;
  logic [7:0] s_addr, s_wdata;

  logic       cs_n, rw_n, bb_n, bin_n;
  logic [7:0] addr_n, pos_n, din_n;
  logic       vld_n, port_n, err_n, bit_n;
  logic [7:0] data_n;

`ifdef DATARAM_SEQ_INDIRECT_EN
  logic       we_q, we_n;
`else
  logic       unused_rs;
  assign unused_rs = ^psw_rs;
`endif

  // p1 wins only when alone or when round-robin says p0 went last
  assign gnt1   = p1_req & (~p0_req | (RR & ~last));
  assign go     = reset & (state == IDLE) & (p0_req | p1_req);
  assign p0_ack = go & ~gnt1;
  assign p1_ack = go & gnt1;

  assign s_we    = gnt1 ? p1_we    : p0_we;
  assign s_bit   = gnt1 ? p1_bit   : p0_bit;
  assign s_ind   = gnt1 ? p1_ind   : p0_ind;
  assign s_addr  = gnt1 ? p1_addr  : p0_addr;
  assign s_wdata = gnt1 ? p1_wdata : p0_wdata;
  assign s_wbit  = gnt1 ? p1_wbit  : p0_wbit;

  // next state and next values of all registered outputs
  always_comb begin
    state_n = state;
    last_n  = last;
    cs_n    = 1'b1;
    rw_n    = 1'b1;
    bb_n    = ram_Bb;
    addr_n  = ram_addr;
    pos_n   = ram_pos;
    din_n   = ram_din;
    bin_n   = ram_bin;
    vld_n   = 1'b0;
    port_n  = rsp_port;
    err_n   = 1'b0;
    data_n  = 8'h00;
    bit_n   = 1'b0;
`ifdef DATARAM_SEQ_INDIRECT_EN
    we_n    = we_q;
`endif
    unique case (state)
      IDLE: begin
        if (go) begin
          last_n = gnt1;
          port_n = gnt1;
          din_n  = s_wdata;
          bin_n  = s_wbit;
`ifdef DATARAM_SEQ_INDIRECT_EN
          we_n   = s_we;
`endif
          if (s_ind) begin
`ifdef DATARAM_SEQ_INDIRECT_EN
            state_n = PTR;
            cs_n    = 1'b0;
            bb_n    = 1'b1;
            pos_n   = 8'hFF;
            addr_n  = {3'b000, psw_rs, 2'b00, s_addr[0]};
`else
            state_n = RSP;
            vld_n   = 1'b1;
            err_n   = 1'b1;
`endif
          end else if (s_bit) begin
            if (s_addr[7]) begin
              state_n = RSP;
              vld_n   = 1'b1;
              err_n   = 1'b1;
            end else begin
              state_n = ACC;
              cs_n    = 1'b0;
              rw_n    = ~s_we;
              bb_n    = 1'b0;
              addr_n  = {4'h2, s_addr[6:3]};
              pos_n   = 8'd1 << s_addr[2:0];
            end
          end else if (s_addr >= ADDR_LIMIT) begin
            state_n = RSP;
            vld_n   = 1'b1;
            err_n   = 1'b1;
          end else begin
            state_n = ACC;
            cs_n    = 1'b0;
            rw_n    = ~s_we;
            bb_n    = 1'b1;
            addr_n  = s_addr;
            pos_n   = 8'hFF;
          end
        end
      end
`ifdef DATARAM_SEQ_INDIRECT_EN
      PTR: begin
        if (ram_dout >= ADDR_LIMIT) begin
          state_n = RSP;
          vld_n   = 1'b1;
          err_n   = 1'b1;
        end else begin
          state_n = ACC;
          cs_n    = 1'b0;
          rw_n    = ~we_q;
          bb_n    = 1'b1;
          addr_n  = ram_dout;
          pos_n   = 8'hFF;
        end
      end
`endif
      ACC: begin
        state_n = RSP;
        vld_n   = 1'b1;
        if (ram_RW) begin
          if (ram_Bb) data_n = ram_dout;
          else        bit_n  = ram_bout;
        end
      end
      RSP: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // state register and round-robin pointer (reset prefers p0)
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      last  <= 1'b1;
    end else begin
      state <= state_n;
      last  <= last_n;
    end
  end

  // registered RAM strobes and response outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ram_CS    <= 1'b1;
      ram_RW    <= 1'b1;
      ram_Bb    <= 1'b1;
      ram_addr  <= 8'h00;
      ram_pos   <= 8'h00;
      ram_din   <= 8'h00;
      ram_bin   <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_port  <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_data  <= 8'h00;
      rsp_bit   <= 1'b0;
    end else begin
      ram_CS    <= cs_n;
      ram_RW    <= rw_n;
      ram_Bb    <= bb_n;
      ram_addr  <= addr_n;
      ram_pos   <= pos_n;
      ram_din   <= din_n;
      ram_bin   <= bin_n;
      rsp_valid <= vld_n;
      rsp_port  <= port_n;
      rsp_err   <= err_n;
      rsp_data  <= data_n;
      rsp_bit   <= bit_n;
    end
  end

`ifdef DATARAM_SEQ_INDIRECT_EN
  // write direction kept across the pointer read
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) we_q <= 1'b0;
    else        we_q <= we_n;
  end
`endif

endmodule
